// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-port AXI4-Lite arbiter: FSM states,
// requester port indices and default protection attributes.
package axi_lite_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP,
    S_RESP
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [2:0] PROT_I_DEF = 3'b100;
  localparam logic [2:0] PROT_D_DEF = 3'b000;

endpackage

// File: rtl/axi_lite_arbiter_rr_grant.sv
// Two-way round-robin grant: a tie goes to the port that did not win last.
module axi_rr_grant
  import axi_lite_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant_valid,
  output logic grant_port
);

  logic last_grant;

  assign grant_valid = req0 | req1;
  assign grant_port  = (req0 && req1) ? ~last_grant : ~req0;

  // Reset to the data port so the fetch port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= PORT_D;
    else if (take) last_grant <= grant_port;
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between instruction fetch (port 0, reads
// only) and data load/store (port 1); one outstanding transaction at a time.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT_I = PROT_I_DEF,
  parameter logic [2:0] PROT_D = PROT_D_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_W-1:0]     addr0,
  output logic [DATA_W-1:0]     rdata0,
  output logic                  done0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [DATA_W/8-1:0]   wstrb1,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  done1,
  output logic                  ARvalid,
  input  logic                  ARready,
  output logic [ADDR_W-1:0]     ARdata,
  output logic [2:0]            ARprot,
  input  logic                  Rvalid,
  output logic                  RReady,
  input  logic [DATA_W-1:0]     Rdata,
  output logic                  AWvalid,
  input  logic                  AWready,
  output logic [ADDR_W-1:0]     AWdata,
  output logic [2:0]            AWprot,
  output logic                  Wvalid,
  input  logic                  Wready,
  output logic [DATA_W-1:0]     Wdata,
  output logic [DATA_W/8-1:0]   Wstrb,
  input  logic                  Bvalid,
  output logic                  Bready
);

  state_t              state;
  logic                gnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [2:0]          prot_q;
  logic                aw_done;
  logic                w_done;

  logic grant_valid;
  logic grant_port;
  logic take;
  logic grant_write;
  logic aw_fin;
  logic w_fin;

  assign take        = (state == S_IDLE) && grant_valid;
  assign grant_write = (grant_port == PORT_D) && we1;
  assign aw_fin      = aw_done | (AWvalid & AWready);
  assign w_fin       = w_done  | (Wvalid  & Wready);

  // Address/data come straight from the capture registers, which only
  // change in IDLE, so they are stable while any valid is high.
  assign ARdata = addr_q;
  assign AWdata = addr_q;
  assign ARprot = prot_q;
  assign AWprot = prot_q;
  assign Wdata  = wdata_q;
  assign Wstrb  = wstrb_q;

  axi_rr_grant u_grant (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt     <= PORT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      prot_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ARvalid <= 1'b0;
      RReady  <= 1'b0;
      AWvalid <= 1'b0;
      Wvalid  <= 1'b0;
      Bready  <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      // NOTE: read-data registers are plain flops, so they are cleared here
      // and a requester never sees X before its first completion.
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            gnt     <= grant_port;
            addr_q  <= (grant_port == PORT_D) ? addr1 : addr0;
            wdata_q <= (grant_port == PORT_D) ? wdata1 : '0;
            wstrb_q <= (grant_port == PORT_D) ? wstrb1 : '0;
            prot_q  <= (grant_port == PORT_D) ? PROT_D : PROT_I;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (grant_write) begin
              AWvalid <= 1'b1;
              Wvalid  <= 1'b1;
              state   <= S_WADDR;
            end else begin
              ARvalid <= 1'b1;
              state   <= S_RADDR;
            end
          end
        end
        S_RADDR: begin
          if (ARready) begin
            ARvalid <= 1'b0;
            RReady  <= 1'b1;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (Rvalid) begin
            RReady <= 1'b0;
            if (gnt == PORT_D) begin
              rdata1 <= Rdata;
              done1  <= 1'b1;
            end else begin
              rdata0 <= Rdata;
              done0  <= 1'b1;
            end
            state <= S_RESP;
          end
        end
        S_WADDR: begin
          // Address and data channels complete independently.
          if (AWvalid && AWready) begin
            AWvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (Wvalid && Wready) begin
            Wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            Bready <= 1'b1;
            state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (Bvalid) begin
            Bready <= 1'b0;
            done1  <= 1'b1;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: a table of single transactions
// against a zero-wait slave, then hand-written multi-cycle corner cases.
module tb_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic [31:0] rdata0;
  logic        done0;
  logic        req1 = 1'b0;
  logic        we1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic [3:0]  wstrb1 = '0;
  logic [31:0] rdata1;
  logic        done1;
  logic        ARvalid, ARready;
  logic [31:0] ARdata;
  logic [2:0]  ARprot;
  logic        Rvalid, RReady;
  logic [31:0] Rdata;
  logic        AWvalid, AWready;
  logic [31:0] AWdata;
  logic [2:0]  AWprot;
  logic        Wvalid, Wready;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Bvalid, Bready;

  always #5 clk = ~clk;

  axi_lite_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
    .rdata1(rdata1), .done1(done1),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
    .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .AWprot(AWprot),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready)
  );

  // Slave model: each ready/valid answers after a programmable wait.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] slave_rdata = '0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arprot, cap_awprot;
  logic [3:0]  cap_wstrb;

  assign ARready = ARvalid && (ar_cnt >= ar_wait);
  assign Rvalid  = RReady  && (r_cnt  >= r_wait);
  assign AWready = AWvalid && (aw_cnt >= aw_wait);
  assign Wready  = Wvalid  && (w_cnt  >= w_wait);
  assign Bvalid  = Bready  && (b_cnt  >= b_wait);
  assign Rdata   = slave_rdata;

  always @(posedge clk) begin
    ar_cnt <= (ARvalid && !ARready) ? ar_cnt + 1 : 0;
    r_cnt  <= (RReady  && !Rvalid)  ? r_cnt  + 1 : 0;
    aw_cnt <= (AWvalid && !AWready) ? aw_cnt + 1 : 0;
    w_cnt  <= (Wvalid  && !Wready)  ? w_cnt  + 1 : 0;
    b_cnt  <= (Bready  && !Bvalid)  ? b_cnt  + 1 : 0;
    if (ARvalid && ARready) begin
      cap_araddr <= ARdata;
      cap_arprot <= ARprot;
    end
    if (AWvalid && AWready) begin
      cap_awaddr <= AWdata;
      cap_awprot <= AWprot;
    end
    if (Wvalid && Wready) begin
      cap_wdata <= Wdata;
      cap_wstrb <= Wstrb;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] srdata;
    logic [2:0]  exp_prot;
    int          exp_lat;
  } vec_t;

  // Raise the request at a negedge; latency counts the request cycle as 1.
  task automatic wait_done(input logic port, output int lat);
    bit found = 0;
    lat = 1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      lat++;
      if ((port ? done1 : done0) === 1'b1) found = 1;
    end
    if (!found) lat = -1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int lat;
    logic other;
    slave_rdata = v.srdata;
    if (v.port) begin
      we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; wstrb1 = v.wstrb; req1 = 1'b1;
    end else begin
      addr0 = v.addr; req0 = 1'b1;
    end
    wait_done(v.port, lat);
    other = v.port ? done0 : done1;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " other done"}, other, 1'b0);
    if (v.we) begin
      check({tag, " awaddr"}, cap_awaddr, v.addr);
      check({tag, " awprot"}, cap_awprot, v.exp_prot);
      check({tag, " wdata"},  cap_wdata,  v.wdata);
      check({tag, " wstrb"},  cap_wstrb,  v.wstrb);
    end else begin
      check({tag, " araddr"}, cap_araddr, v.addr);
      check({tag, " arprot"}, cap_arprot, v.exp_prot);
      check({tag, " rdata"},  v.port ? rdata1 : rdata0, v.srdata);
    end
    @(negedge clk);
    check({tag, " done width"}, {done0, done1}, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 3'b100, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 32'h0,         3'b000, 4};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'h0, 32'hA5A5_0F0F, 3'b000, 4};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0001, 3'b100, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         3'b000, 4};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset valids", {ARvalid, RReady, AWvalid, Wvalid, Bready}, 5'b0);
    check("reset done",   {done0, done1}, 2'b00);
    check("reset rdata0", rdata0, 32'h0);
    check("reset rdata1", rdata1, 32'h0);

    for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), vecs[i]);
    check("rdata0 held", rdata0, 32'h0000_0001);
    check("rdata1 held", rdata1, 32'hA5A5_0F0F);

    // Write with AWready two cycles ahead of Wready.
    begin
      logic exp_aw[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic exp_w[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic exp_b[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      int   ndone = 0;
      w_wait = 2;
      we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h1234_5678; wstrb1 = 4'b0011; req1 = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("skew cyc%0d aw/w/b", c), {AWvalid, Wvalid, Bready},
              {exp_aw[c], exp_w[c], exp_b[c]});
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done1) begin ndone++; req1 = 1'b0; end
      end
      check("skew done1 count", ndone, 1);
      check("skew wdata", cap_wdata, 32'h1234_5678);
      check("skew wstrb", cap_wstrb, 4'b0011);
      w_wait = 0;
    end

    // Both requesters held: grants must alternate starting with port 0.
    begin
      logic exp_g[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int   ng = 0;
      bit   re0 = 0, re1 = 0, prev_done = 0;
      do_reset();
      we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20; slave_rdata = 32'h5555_AAAA;
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 100 && ng < 4; c++) begin
        @(negedge clk);
        if (re0) begin req0 = 1'b1; re0 = 0; end
        if (re1) begin req1 = 1'b1; re1 = 0; end
        if (done0 || done1) begin
          check("alt no double done", prev_done, 1'b0);
          check($sformatf("alt grant%0d", ng), {done0, done1},
                exp_g[ng] ? 2'b01 : 2'b10);
          ng++;
          if (done0) begin req0 = 1'b0; re0 = 1; end
          if (done1) begin req1 = 1'b0; re1 = 1; end
        end
        prev_done = done0 || done1;
      end
      check("alt grant count", ng, 4);
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(negedge clk);
    end

    // ARready held off for 5 cycles: address and prot must not move.
    begin
      int  hi = 0;
      bit  stable = 1, fin = 0;
      int  lat;
      do_reset();
      ar_wait = 5; slave_rdata = 32'h0BAD_F00D;
      addr0 = 32'h400; req0 = 1'b1;
      for (int c = 0; c < 20 && !fin; c++) begin
        @(negedge clk);
        addr0 = 32'hFFFF_0000;
        if (ARvalid) begin
          hi++;
          if (ARdata !== 32'h400 || ARprot !== 3'b100) stable = 0;
        end else if (hi > 0) fin = 1;
      end
      check("arwait valid cycles", hi, 6);
      check("arwait stable", stable, 1'b1);
      wait_done(1'b0, lat);
      check("arwait found done", lat > 0, 1'b1);
      check("arwait rdata0", rdata0, 32'h0BAD_F00D);
      ar_wait = 0;
      @(negedge clk);
    end

    // Reset while waiting for read data, then a fresh port-1 read.
    begin
      bit in_rdata = 0;
      vec_t v;
      r_wait = 10; we1 = 1'b0; addr1 = 32'h500; req1 = 1'b1;
      for (int c = 0; c < 10 && !in_rdata; c++) begin
        @(negedge clk);
        if (RReady) in_rdata = 1;
      end
      check("rst reached rdata", in_rdata, 1'b1);
      rst = 1'b1; req1 = 1'b0;
      @(negedge clk);
      check("rst valids", {ARvalid, RReady, AWvalid, Wvalid, Bready}, 5'b0);
      check("rst done",   {done0, done1}, 2'b00);
      check("rst rdata1", rdata1, 32'h0);
      rst = 1'b0; r_wait = 0;
      @(negedge clk);
      v = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'hCAFE_F00D, 3'b000, 4};
      run_txn("post-rst", v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
